// File: rtl/risc16_pkg.sv
// Shared constants for the RiSC-16 execute datapath: widths and ALU function codes.
package risc16_pkg;

   localparam int WIDTH     = 16;
   localparam int IMM_W     = 10;
   localparam int SIMM_W    = 7;
   localparam int LUI_SHIFT = WIDTH - IMM_W;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_NAND  = 2'b01;
   localparam logic [1:0] ALU_PASS1 = 2'b10;
   localparam logic [1:0] ALU_EQL   = 2'b11;

endpackage

// File: rtl/risc16_alu_opsel.sv
// Operand selection for the ALU: register sources, LUI-shifted immediate or
// sign-extended short immediate. Purely combinational.
module risc16_alu_opsel
   import risc16_pkg::*;
#(
   parameter int P_WIDTH     = WIDTH,
   parameter int P_IMM_W     = IMM_W,
   parameter int P_SIMM_W    = SIMM_W,
   parameter int P_LUI_SHIFT = LUI_SHIFT
) (
   input  logic                 i_mux_alu1,
   input  logic                 i_mux_alu2,
   input  logic [P_WIDTH-1:0]   i_src1,
   input  logic [P_WIDTH-1:0]   i_src2,
   input  logic [P_IMM_W-1:0]   i_imm,
   output logic [P_WIDTH-1:0]   o_op1,
   output logic [P_WIDTH-1:0]   o_op2
);

   logic [P_WIDTH-1:0] w_imm_lui;
   logic [P_WIDTH-1:0] w_imm_sext;

   // The upper immediate bits are deliberately dropped here: ADDI/LW/SW use a 7-bit signed field.
   assign w_imm_lui  = {i_imm, {P_LUI_SHIFT{1'b0}}};
   assign w_imm_sext = {{(P_WIDTH-P_SIMM_W){i_imm[P_SIMM_W-1]}}, i_imm[P_SIMM_W-1:0]};

   assign o_op1 = i_mux_alu1 ? w_imm_lui  : i_src1;
   assign o_op2 = i_mux_alu2 ? w_imm_sext : i_src2;

endmodule

// File: rtl/risc16_alu.sv
// RiSC-16 ALU: ADD / NAND / PASS1 / EQL with an equality flag, outputs registered
// with one cycle of latency.
module risc16_alu
   import risc16_pkg::*;
#(
   parameter int P_WIDTH     = WIDTH,
   parameter int P_IMM_W     = IMM_W,
   parameter int P_SIMM_W    = SIMM_W,
   parameter int P_LUI_SHIFT = LUI_SHIFT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 MUX_alu1,
   input  logic                 MUX_alu2,
   input  logic [1:0]           FUNC_alu,
   input  logic [P_WIDTH-1:0]   src1_reg,
   input  logic [P_WIDTH-1:0]   src2_reg,
   input  logic [P_IMM_W-1:0]   imm,
   output logic                 EQ,
   output logic [P_WIDTH-1:0]   alu_out
);

   logic [P_WIDTH-1:0] w_op1;
   logic [P_WIDTH-1:0] w_op2;
   logic [P_WIDTH-1:0] w_result;
   logic               w_eq;
   logic [P_WIDTH-1:0] r_alu_out;
   logic               r_eq;

   risc16_alu_opsel #(
      .P_WIDTH     (P_WIDTH),
      .P_IMM_W     (P_IMM_W),
      .P_SIMM_W    (P_SIMM_W),
      .P_LUI_SHIFT (P_LUI_SHIFT)
   ) u_opsel (
      .i_mux_alu1 (MUX_alu1),
      .i_mux_alu2 (MUX_alu2),
      .i_src1     (src1_reg),
      .i_src2     (src2_reg),
      .i_imm      (imm),
      .o_op1      (w_op1),
      .o_op2      (w_op2)
   );

   // EQ compares operands for every function so BEQ can share any operand routing.
   assign w_eq = (w_op1 == w_op2);

   always_comb begin
      w_result = '0;
      case (FUNC_alu)
         ALU_ADD:   w_result = w_op1 + w_op2;
         ALU_NAND:  w_result = ~(w_op1 & w_op2);
         ALU_PASS1: w_result = w_op1;
         default:   w_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_out <= '0;
         r_eq      <= 1'b0;
      end else begin
         r_alu_out <= w_result;
         r_eq      <= w_eq;
      end
   end

   assign alu_out = r_alu_out;
   assign EQ      = r_eq;

endmodule

// File: tb/tb_risc16_alu.sv
// Bench for risc16_alu: directed plan steps followed by random operations, each
// checked one clock later against an integer-arithmetic model of the ALU rules.
module tb_risc16_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        MUX_alu1;
   logic        MUX_alu2;
   logic [1:0]  FUNC_alu;
   logic [15:0] src1_reg;
   logic [15:0] src2_reg;
   logic [9:0]  imm;
   logic        EQ;
   logic [15:0] alu_out;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] prev_out;
   logic        prev_eq;
   bit          have_prev = 0;

   always #5 clk = ~clk;

   risc16_alu dut (
      .clk      (clk),
      .rst      (rst),
      .MUX_alu1 (MUX_alu1),
      .MUX_alu2 (MUX_alu2),
      .FUNC_alu (FUNC_alu),
      .src1_reg (src1_reg),
      .src2_reg (src2_reg),
      .imm      (imm),
      .EQ       (EQ),
      .alu_out  (alu_out)
   );

   // Reference model in plain integer arithmetic.
   function automatic void model(input logic r, input logic m1, input logic m2,
                                 input logic [1:0] f, input logic [15:0] s1,
                                 input logic [15:0] s2, input logic [9:0] im,
                                 output logic [15:0] res, output logic eq);
      int a, b, lo7, v;
      lo7 = int'(im) % 128;
      a = m1 ? (int'(im) * 64) % 65536 : int'(s1);
      b = m2 ? ((lo7 >= 64) ? lo7 - 128 + 65536 : lo7) : int'(s2);
      case (int'(f))
         0:       v = (a + b) % 65536;
         1:       v = 65535 - (a & b);
         2:       v = a;
         default: v = 0;
      endcase
      if (r) begin
         res = 16'h0000;
         eq  = 1'b0;
      end else begin
         res = v[15:0];
         eq  = (a == b);
      end
   endfunction

   task automatic step(input logic r, input logic m1, input logic m2, input logic [1:0] f,
                       input logic [15:0] s1, input logic [15:0] s2, input logic [9:0] im,
                       input string tag);
      logic [15:0] exp_out;
      logic        exp_eq;
      rst = r; MUX_alu1 = m1; MUX_alu2 = m2; FUNC_alu = f;
      src1_reg = s1; src2_reg = s2; imm = im;
      model(r, m1, m2, f, s1, s2, im, exp_out, exp_eq);
      #1;
      if (have_prev) begin
         checks++;
         assert (alu_out === prev_out) else begin
            failures++;
            $error("FAIL %s_hold alu_out got=%h exp=%h", tag, alu_out, prev_out);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      assert (alu_out === exp_out) else begin
         failures++;
         $error("FAIL %s alu_out got=%h exp=%h", tag, alu_out, exp_out);
      end
      checks++;
      assert (EQ === exp_eq) else begin
         failures++;
         $error("FAIL %s EQ got=%b exp=%b", tag, EQ, exp_eq);
      end
      $display("step %s rst=%b mux=%b%b f=%0d s1=%h s2=%h imm=%h -> out=%h eq=%b",
               tag, r, m1, m2, f, s1, s2, im, alu_out, EQ);
      prev_out  = exp_out;
      prev_eq   = exp_eq;
      have_prev = 1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset with arbitrary inputs, then the first result.
      step(1, 1, 1, 2'b10, 16'hBEEF, 16'hBEEF, 10'h3FF, "reset");
      step(0, 0, 0, 2'b00, 16'd10,   16'd20,   10'h000, "add_after_rst");
      // ADD reg-reg
      step(0, 0, 0, 2'b00, 16'hFFFF, 16'h0001, 10'h155, "add_wrap");
      step(0, 0, 0, 2'b00, 16'd55,   16'd55,   10'h000, "add_eq");
      // ADDI
      step(0, 0, 1, 2'b00, 16'd100,  16'hAAAA, 10'd5,          "addi_pos");
      step(0, 0, 1, 2'b00, 16'd50,   16'h0000, 10'b1111110100, "addi_neg");
      step(0, 0, 1, 2'b00, 16'd50,   16'h0000, 10'b0001110100, "addi_hi_ign");
      // NAND
      step(0, 0, 0, 2'b01, 16'hAAAA, 16'h5555, 10'h000, "nand_a");
      step(0, 0, 0, 2'b01, 16'hFFFF, 16'hFFFF, 10'h000, "nand_b");
      // PASS1 / LUI
      step(0, 0, 0, 2'b10, 16'hBEEF, 16'hDEAD, 10'h000,        "pass1");
      step(0, 1, 0, 2'b10, 16'hBEEF, 16'hDEAD, 10'b1100110011, "lui");
      // EQL
      step(0, 0, 0, 2'b11, 16'h1234, 16'h1234, 10'h000, "eql_eq");
      step(0, 0, 0, 2'b11, 16'h1234, 16'h4321, 10'h000, "eql_ne");
      // Both immediates together
      step(0, 1, 1, 2'b00, 16'h0000, 16'h0000, 10'b1001000011, "imm_imm_add");
      // Reset mid-stream kills the in-flight result
      step(0, 0, 0, 2'b00, 16'h7000, 16'h0123, 10'h000, "pre_rst");
      step(1, 0, 0, 2'b10, 16'h5A5A, 16'h5A5A, 10'h000, "mid_rst");
      step(0, 0, 0, 2'b10, 16'h5A5A, 16'h5A5A, 10'h000, "post_rst");
      // Random back-to-back operations, one per cycle
      for (int i = 0; i < 200; i++) begin
         logic [15:0] s1, s2;
         s1 = 16'($urandom);
         s2 = ($urandom_range(0, 3) == 0) ? s1 : 16'($urandom);
         step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
              s1, s2, 10'($urandom), $sformatf("rnd%0d", i));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
